// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencing, branch redirection and IF/ID register.
// Ports: clk, rst (async active-low), hazard/branch controls, IM bus, IF/ID.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PC_write,
    input  logic        IFID_RegWrite,
    input  logic        instrFlush,
    input  logic [1:0]  BranchCtrl,
    input  logic [31:0] pc_imm,
    input  logic [31:0] pc_jalr,
    output logic [31:0] im_addr,
    input  logic [31:0] im_dout,
    input  logic        im_ready,
    output logic [31:0] IFID_pc,
    output logic [31:0] IFID_instr,
    output logic        IFID_valid
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        REDIR_WAIT
    } state_t;

    state_t      state;
    state_t      stateNext;
    logic [31:0] pc;
    logic [31:0] pcNext;
    logic [31:0] redirPc;
    logic [31:0] redirNext;
    logic [31:0] target;
    logic [31:0] pcPlus4;
    logic [31:0] addrNext;
    logic        branch;
    logic        fetchOk;
    logic        bubble;
    logic        ifidLoad;

    assign branch  = (BranchCtrl != 2'b00);
    assign fetchOk = (state == RUN) && im_ready;
    assign pcPlus4 = pc + 32'd4;

    always_comb begin
        target = pc_imm;
        unique case (1'b1)
            (BranchCtrl == 2'b10): target = {pc_jalr[31:1], 1'b0};
            default:               target = pc_imm;
        endcase
    end

    // pc always names the word arriving on im_dout this cycle, so
    // im_addr is either pc (re-request) or the next address to load.
    always_comb begin
        stateNext = state;
        pcNext    = pc;
        redirNext = redirPc;
        addrNext  = pc;
        unique case (state)
            BOOT: begin
                stateNext = RUN;
                if (branch) begin
                    addrNext = target;
                    pcNext   = target;
                end
            end
            RUN: begin
                if (branch) begin
                    if (im_ready) begin
                        addrNext = target;
                        pcNext   = target;
                    end else begin
                        redirNext = target;
                        stateNext = REDIR_WAIT;
                    end
                end else if (fetchOk && PC_write) begin
                    addrNext = pcPlus4;
                    pcNext   = pcPlus4;
                end
            end
            REDIR_WAIT: begin
                // A newer branch supersedes the parked target.
                if (branch) begin
                    redirNext = target;
                end
                if (im_ready) begin
                    addrNext  = branch ? target : redirPc;
                    pcNext    = addrNext;
                    stateNext = RUN;
                end
            end
            default: begin
                stateNext = BOOT;
            end
        endcase
    end

    assign im_addr = rst ? addrNext : RESET_PC;

    assign ifidLoad = IFID_RegWrite || instrFlush;
    assign bubble   = instrFlush || branch || !fetchOk;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= BOOT;
            pc         <= RESET_PC;
            redirPc    <= 32'd0;
            IFID_pc    <= 32'd0;
            IFID_instr <= NOP_INSTR;
            IFID_valid <= 1'b0;
        end else begin
            state   <= stateNext;
            pc      <= pcNext;
            redirPc <= redirNext;
            if (ifidLoad) begin
                IFID_pc <= pc;
                if (bubble) begin
                    IFID_instr <= NOP_INSTR;
                    IFID_valid <= 1'b0;
                end else begin
                    IFID_instr <= im_dout;
                    IFID_valid <= 1'b1;
                end
            end
        end
    end

endmodule
